// File: rtl/vdp_vram_arbiter.sv
// Single-port VRAM arbiter: merges CPU-side IO accesses and renderer fetch reads.
// Renderer has priority; a burst limit bounds how long a pending IO access can wait.
module vdp_vram_arbiter #(
  parameter int unsigned ADDR_W        = 14,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned MAX_REN_BURST = 4
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              io_go,
  input  logic              io_re,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic [DATA_W-1:0] io_rdata,
  output logic              io_busy,
  input  logic              ren_req,
  input  logic [ADDR_W-1:0] ren_addr,
  output logic              ren_ack,
  output logic              ren_valid,
  output logic [DATA_W-1:0] ren_rdata,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [DATA_W-1:0] vram_wdata,
  input  logic [DATA_W-1:0] vram_rdata
);

  localparam int unsigned StreakW = $clog2(MAX_REN_BURST + 1);

  typedef enum logic [2:0] {StIdle, StRenRd, StRenData, StIoAcc, StIoData} state_e;

  state_e              state_q;
  logic                io_pend_q;
  logic                io_wr_q;
  logic [ADDR_W-1:0]   io_addr_q;
  logic [DATA_W-1:0]   io_wdata_q;
  logic [DATA_W-1:0]   io_rdata_q;
  logic [DATA_W-1:0]   ren_rdata_q;
  logic [StreakW-1:0]  streak_q;
  logic [ADDR_W-1:0]   vram_addr_q;
  logic                vram_we_q;
  logic [DATA_W-1:0]   vram_wdata_q;

  logic io_win, ren_win, io_done, io_accept;

  assign io_win    = (state_q == StIdle) && io_pend_q &&
                     (!ren_req || (streak_q == StreakW'(MAX_REN_BURST)));
  assign ren_win   = (state_q == StIdle) && !io_win && ren_req;
  assign io_done   = ((state_q == StIoAcc) && io_wr_q) || (state_q == StIoData);
  // A new request may be captured in the same cycle the pending one retires.
  assign io_accept = io_go && (io_re || io_we) && (!io_pend_q || io_done);

  // Gating with reset_L keeps the reset cycle free of grants and writes.
  assign ren_ack    = ren_win & reset_L;
  assign ren_valid  = (state_q == StRenData) & reset_L;
  assign ren_rdata  = ren_valid ? vram_rdata : ren_rdata_q;
  assign vram_we    = vram_we_q & reset_L;
  assign vram_addr  = vram_addr_q;
  assign vram_wdata = vram_wdata_q;
  assign io_busy    = io_pend_q;
  assign io_rdata   = io_rdata_q;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q      <= StIdle;
      io_pend_q    <= 1'b0;
      io_wr_q      <= 1'b0;
      io_addr_q    <= '0;
      io_wdata_q   <= '0;
      io_rdata_q   <= '0;
      ren_rdata_q  <= '0;
      streak_q     <= '0;
      vram_addr_q  <= '0;
      vram_we_q    <= 1'b0;
      vram_wdata_q <= '0;
    end else begin
      vram_addr_q  <= '0;
      vram_we_q    <= 1'b0;
      vram_wdata_q <= '0;

      if (io_accept) begin
        io_addr_q  <= io_addr;
        io_wdata_q <= io_wdata;
        io_wr_q    <= io_we;
        io_pend_q  <= 1'b1;
      end else if (io_done) begin
        io_pend_q  <= 1'b0;
      end

      if (!io_pend_q || io_win) begin
        streak_q <= '0;
      end else if (ren_win && (streak_q < StreakW'(MAX_REN_BURST))) begin
        streak_q <= streak_q + StreakW'(1);
      end

      case (state_q)
        StIdle: begin
          if (io_win) begin
            state_q      <= StIoAcc;
            vram_addr_q  <= io_addr_q;
            vram_we_q    <= io_wr_q;
            vram_wdata_q <= io_wr_q ? io_wdata_q : '0;
          end else if (ren_win) begin
            state_q     <= StRenRd;
            vram_addr_q <= ren_addr;
          end
        end
        StRenRd:   state_q <= StRenData;
        StRenData: begin
          ren_rdata_q <= vram_rdata;
          state_q     <= StIdle;
        end
        StIoAcc:   state_q <= io_wr_q ? StIdle : StIoData;
        StIoData: begin
          io_rdata_q <= vram_rdata;
          state_q    <= StIdle;
        end
        default:   state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Directed bench for vdp_vram_arbiter with a behavioural synchronous VRAM.
module tb_vdp_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset_L;
  logic        io_go, io_re, io_we;
  logic [13:0] io_addr;
  logic [7:0]  io_wdata, io_rdata;
  logic        io_busy;
  logic        ren_req;
  logic [13:0] ren_addr;
  logic        ren_ack, ren_valid;
  logic [7:0]  ren_rdata;
  logic [13:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata, vram_rdata;

  logic [7:0]  mem [0:16383];
  logic        init_mem;
  int          wr_cnt = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  vdp_vram_arbiter dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .io_go      (io_go),
    .io_re      (io_re),
    .io_we      (io_we),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata),
    .io_busy    (io_busy),
    .ren_req    (ren_req),
    .ren_addr   (ren_addr),
    .ren_ack    (ren_ack),
    .ren_valid  (ren_valid),
    .ren_rdata  (ren_rdata),
    .vram_addr  (vram_addr),
    .vram_we    (vram_we),
    .vram_wdata (vram_wdata),
    .vram_rdata (vram_rdata)
  );

  // Synchronous RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 8'h00;
      mem[14'h3FFF] <= 8'h5A;
      mem[14'h0400] <= 8'h77;
      mem[14'h0021] <= 8'hEE;
      vram_rdata    <= 8'h00;
    end else begin
      if (vram_we) begin
        mem[vram_addr] <= vram_wdata;
        wr_cnt         <= wr_cnt + 1;
      end
      vram_rdata <= mem[vram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drv_edge();
      io_go = 1'b0;
    end
  endtask

  task automatic io_req(input logic we, input logic re, input logic [13:0] a,
                        input logic [7:0] d);
    io_go = 1'b1; io_we = we; io_re = re; io_addr = a; io_wdata = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int w0, acks, nwr;
    logic resumed;
    logic [13:0] w_addr;
    logic [7:0]  w_data;

    init_mem = 1'b1;
    reset_L  = 1'b0;
    io_go = 0; io_re = 0; io_we = 0; io_addr = '0; io_wdata = '0;
    ren_req = 0; ren_addr = '0;
    drv_edge();
    init_mem = 1'b0;
    drv_edge();
    smp();
    check_eq("rst_vram_we", {31'd0, vram_we}, 0);
    check_eq("rst_io_busy", {31'd0, io_busy}, 0);
    check_eq("rst_ren_ack", {31'd0, ren_ack}, 0);
    check_eq("rst_ren_valid", {31'd0, ren_valid}, 0);
    check_eq("rst_vram_addr", {18'd0, vram_addr}, 0);
    check_eq("rst_io_rdata", {24'd0, io_rdata}, 0);
    drv_edge();
    reset_L = 1'b1;
    idle(2);

    // IO write, uncontended
    drv_edge(); io_req(1, 0, 14'h0123, 8'hA5);
    smp(); check_eq("wr_c0_we", {31'd0, vram_we}, 0);
    drv_edge(); io_go = 0;
    smp(); check_eq("wr_c1_busy", {31'd0, io_busy}, 1);
    check_eq("wr_c1_we", {31'd0, vram_we}, 0);
    drv_edge();
    smp(); check_eq("wr_c2_we", {31'd0, vram_we}, 1);
    check_eq("wr_c2_addr", {18'd0, vram_addr}, 32'h0123);
    check_eq("wr_c2_data", {24'd0, vram_wdata}, 32'hA5);
    check_eq("wr_c2_busy", {31'd0, io_busy}, 1);
    drv_edge();
    smp(); check_eq("wr_c3_we", {31'd0, vram_we}, 0);
    check_eq("wr_c3_wdata", {24'd0, vram_wdata}, 0);
    check_eq("wr_c3_busy", {31'd0, io_busy}, 0);
    check_eq("wr_mem", {24'd0, mem[14'h0123]}, 32'hA5);
    idle(2);

    // IO read of the top address
    w0 = wr_cnt;
    drv_edge(); io_req(0, 1, 14'h3FFF, 8'h00);
    drv_edge(); io_go = 0;
    drv_edge();
    smp(); check_eq("rd_c2_addr", {18'd0, vram_addr}, 32'h3FFF);
    drv_edge();
    smp(); check_eq("rd_c3_busy", {31'd0, io_busy}, 1);
    drv_edge();
    smp(); check_eq("rd_c4_busy", {31'd0, io_busy}, 0);
    check_eq("rd_c4_rdata", {24'd0, io_rdata}, 32'h5A);
    check_eq("rd_no_write", wr_cnt - w0, 0);
    idle(2);

    // io_go with neither re nor we is ignored
    drv_edge(); io_req(0, 0, 14'h0055, 8'hFF);
    drv_edge(); io_go = 0;
    smp(); check_eq("nop_busy", {31'd0, io_busy}, 0);
    idle(2);

    // we wins over re
    drv_edge(); io_req(1, 1, 14'h0050, 8'h66);
    idle(5);
    smp(); check_eq("wewin_mem", {24'd0, mem[14'h0050]}, 32'h66);
    check_eq("wewin_rdata", {24'd0, io_rdata}, 32'h5A);

    // Renderer read
    drv_edge(); ren_req = 1; ren_addr = 14'h0400;
    smp(); check_eq("ren_ack_n", {31'd0, ren_ack}, 1);
    drv_edge(); ren_req = 0;
    smp(); check_eq("ren_ack_n1", {31'd0, ren_ack}, 0);
    check_eq("ren_addr_n1", {18'd0, vram_addr}, 32'h0400);
    drv_edge();
    smp(); check_eq("ren_valid_n2", {31'd0, ren_valid}, 1);
    check_eq("ren_rdata_n2", {24'd0, ren_rdata}, 32'h77);
    drv_edge();
    smp(); check_eq("ren_valid_n3", {31'd0, ren_valid}, 0);
    check_eq("ren_rdata_hold", {24'd0, ren_rdata}, 32'h77);
    idle(2);

    // Contention: renderer streams, IO write must get in after 4 grants
    drv_edge(); ren_req = 1; ren_addr = 14'h0100;
    idle(5);
    acks = 0; nwr = 0; resumed = 0; w_addr = '0; w_data = '0;
    for (int c = 0; c < 60 && !resumed; c++) begin
      drv_edge();
      if (c == 0) io_req(1, 0, 14'h0010, 8'h3C);
      else io_go = 0;
      smp();
      if (vram_we) begin
        nwr++; w_addr = vram_addr; w_data = vram_wdata;
      end
      if (ren_ack) begin
        if (nwr == 0 && io_busy) acks++;
        else if (nwr > 0) resumed = 1;
      end
    end
    check_eq("cont_acks", acks, 4);
    check_eq("cont_nwr", nwr, 1);
    check_eq("cont_addr", {18'd0, w_addr}, 32'h0010);
    check_eq("cont_data", {24'd0, w_data}, 32'h3C);
    check_eq("cont_resume", {31'd0, resumed}, 1);
    drv_edge(); ren_req = 0; io_we = 0;
    idle(4);

    // Overrun: second io_go while pending is dropped
    w0 = wr_cnt;
    drv_edge(); io_req(1, 0, 14'h0020, 8'h11);
    drv_edge(); io_req(1, 0, 14'h0021, 8'h22);
    idle(6);
    smp(); check_eq("ovr_cnt", wr_cnt - w0, 1);
    check_eq("ovr_mem20", {24'd0, mem[14'h0020]}, 32'h11);
    check_eq("ovr_mem21", {24'd0, mem[14'h0021]}, 32'hEE);

    // io_go in the completing cycle is captured
    w0 = wr_cnt;
    drv_edge(); io_req(1, 0, 14'h0030, 8'h44);
    drv_edge(); io_go = 0;
    drv_edge(); io_req(1, 0, 14'h0031, 8'h55);
    drv_edge(); io_go = 0;
    smp(); check_eq("sbc_busy", {31'd0, io_busy}, 1);
    idle(4);
    smp(); check_eq("sbc_cnt", wr_cnt - w0, 2);
    check_eq("sbc_mem30", {24'd0, mem[14'h0030]}, 32'h44);
    check_eq("sbc_mem31", {24'd0, mem[14'h0031]}, 32'h55);

    // Reset while an IO write is pending
    w0 = wr_cnt;
    drv_edge(); io_req(1, 0, 14'h0040, 8'h99);
    drv_edge(); io_go = 0; reset_L = 0;
    smp(); check_eq("rmid_we", {31'd0, vram_we}, 0);
    drv_edge(); reset_L = 1;
    smp(); check_eq("rmid_busy", {31'd0, io_busy}, 0);
    check_eq("rmid_we2", {31'd0, vram_we}, 0);
    check_eq("rmid_addr", {18'd0, vram_addr}, 0);
    check_eq("rmid_ren_valid", {31'd0, ren_valid}, 0);
    check_eq("rmid_ren_rdata", {24'd0, ren_rdata}, 0);
    check_eq("rmid_io_rdata", {24'd0, io_rdata}, 0);
    idle(5);
    smp(); check_eq("rmid_cnt", wr_cnt - w0, 0);
    check_eq("rmid_mem", {24'd0, mem[14'h0040]}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
